// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and defaults for the instruction fetch unit
// Purpose: default widths, fetch FSM state encoding and the fetch-entry layout.
// Ports: none (package).
package ifu_pkg;

  localparam int IFU_PC_W   = 16;
  localparam int IFU_INST_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } ifu_state_e;

  // Layout of one prefetch FIFO entry; the top packs {pc, inst} in this order.
  typedef struct packed {
    logic [IFU_PC_W-1:0]   pc;
    logic [IFU_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - prefetch FIFO holding {pc, inst} entries
// Purpose: DEPTH-entry FIFO (DEPTH a power of 2) with push, pop and flush.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (pointers/count only)
//   push, push_data     write an entry (ignored when full unless popping)
//   pop                 remove the head entry (ignored when empty)
//   flush               empty the FIFO; wins over push in the same cycle
//   head_data           entry at the head (contents undefined when empty)
//   count               number of valid entries, 0..DEPTH
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    // Pointers wrap naturally because DEPTH is a power of 2.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - prefetching instruction fetch stage
// Purpose: issues in-order word reads to instruction memory, buffers the
//   returned instructions with their PCs and hands them to decode; execute
//   redirects flush the buffer and stale in-flight responses are discarded.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   fetch_en                 1 = allow new memory requests
//   imem_req_*               request valid/ready/word address
//   imem_rsp_valid/data      in-order read responses (latency >= 1)
//   redirect_valid/pc        PC change from execute (one-cycle pulse)
//   dec_valid/ready/inst/pc  hand-off to decode
//   perf_fetched/flushes     optional counters, present only with IFU_PERF_CNT_EN
// Configuration macro: IFU_PERF_CNT_EN.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = IFU_PC_W,
  parameter int              INST_W   = IFU_INST_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [INST_W-1:0] dec_inst,
  output logic [PC_W-1:0]   dec_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [15:0]       perf_flushes
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_e         state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  // PC of the next response that will be kept; responses return in issue order.
  logic [PC_W-1:0]    rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]      outstanding_q, outstanding_d;
  logic [CW-1:0]      drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]      fifo_count;
  logic [PC_W+INST_W-1:0] head_data;
  logic [CW:0]        in_use;
  logic               req_fire, redirect, push, pop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  if (!fetch_en) state_d = ST_HALT;
      ST_HALT: if (fetch_en) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    // Buffer space is reserved at issue time, so a response always has a slot.
    in_use         = (CW+1)'(outstanding_q) + (CW+1)'(fifo_count);
    imem_req_valid = (state_q == ST_RUN) && (in_use < (CW+1)'(DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
    redirect       = redirect_valid && (state_q != ST_IDLE);
    dec_valid      = (fifo_count != '0);
    pop            = dec_valid && dec_ready;
    push           = imem_rsp_valid && (drop_cnt_q == '0) && !redirect;

    outstanding_d  = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_cnt_d     = drop_cnt_q - CW'(imem_rsp_valid && (drop_cnt_q != '0));
    fetch_pc_d     = fetch_pc_q + PC_W'(req_fire);
    rsp_pc_d       = rsp_pc_q + PC_W'(push);

    if (redirect) begin
      // Everything still in flight after this edge (including a request
      // accepted right now with the old PC) belongs to the old stream.
      drop_cnt_d = outstanding_d;
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  ifu_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W + INST_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({rsp_pc_q, imem_rsp_data}),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head_data),
    .count     (fifo_count)
  );

  assign imem_req_addr = fetch_pc_q;
  // Storage is not reset, so the head is masked to zero while empty.
  assign dec_inst = dec_valid ? head_data[INST_W-1:0] : '0;
  assign dec_pc   = dec_valid ? head_data[PC_W+INST_W-1:INST_W] : '0;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [15:0] perf_flushes_q, perf_flushes_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_flushes_d = perf_flushes_q;
    if (pop && (perf_fetched_q != '1)) perf_fetched_d = perf_fetched_q + 32'd1;
    if (redirect && (perf_flushes_q != '1)) perf_flushes_d = perf_flushes_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_inst;
  logic [15:0] dec_pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [15:0] perf_flushes;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH), .PC_W(16), .INST_W(32), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [15:0] a);
    return {~a, a} ^ 32'h5A00_00A5;
  endfunction

  // Reference model: memory requests tagged with the fetch stream ("epoch")
  // they belong to; a response from an older stream never reaches decode.
  typedef struct {
    logic [15:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [15:0] m_q[$];
  logic [15:0] pop_log[$];
  logic [15:0] m_fetch_pc = RESET_PC;
  logic [15:0] rsp_addr = '0;
  int          rsp_epoch = 0;
  int          epoch = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          mem_lat = 1;
  int          drops = 0;
  bit          m_idle = 1'b1;
  bit          m_halt = 1'b0;

  task automatic tick();
    bit acc, pop, redir, exp_rv;
    int due;
    mreq_t r;
    exp_rv = !m_idle && !m_halt &&
             ((mem_q.size() + int'(imem_rsp_valid) + m_q.size()) < DEPTH);
    check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (imem_req_valid) check("req_addr", 64'(imem_req_addr), 64'(m_fetch_pc));
    check("dec_valid", 64'(dec_valid), 64'(m_q.size() != 0));
    if (dec_valid && m_q.size() != 0) begin
      check("dec_pc", 64'(dec_pc), 64'(m_q[0]));
      check("dec_inst", 64'(dec_inst), 64'(inst_of(m_q[0])));
    end
    acc   = imem_req_valid && imem_req_ready;
    pop   = dec_valid && dec_ready;
    redir = redirect_valid && !m_idle;
    if (pop) begin
      pop_log.push_back(dec_pc);
      if (m_q.size() != 0) void'(m_q.pop_front());
    end
    if (imem_rsp_valid) begin
      if (rsp_epoch == epoch && !redir) m_q.push_back(rsp_addr);
      else drops++;
    end
    if (acc) begin
      due = cyc + mem_lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{imem_req_addr, epoch, due});
      m_fetch_pc = m_fetch_pc + 16'd1;
    end
    if (redir) begin
      m_q.delete();
      epoch++;
      m_fetch_pc = redirect_pc;
    end
    if (m_idle) m_idle = 1'b0;
    else if (!m_halt && !fetch_en) m_halt = 1'b1;
    else if (m_halt && fetch_en) m_halt = 1'b0;

    @(posedge clk);
    @(negedge clk);
    cyc++;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(r.addr);
      rsp_addr  = r.addr;
      rsp_epoch = r.epoch;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    mem_q.delete();
    m_q.delete();
    epoch++;
    m_idle = 1'b1;
    m_halt = 1'b0;
    m_fetch_pc = RESET_PC;
    last_due = cyc;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int          lat;
    logic [15:0] pc;
    int          n;
    int          delay;
    logic [15:0] last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int k, n, pops0, drops0;
    logic [15:0] exp_pop;

    vecs[0] = '{1, 16'h0040, 4, 2, 16'h0043};
    vecs[1] = '{2, 16'h1234, 5, 3, 16'h1238};
    vecs[2] = '{3, 16'h0040, 3, 4, 16'h0042};
    vecs[3] = '{1, 16'hFFFF, 2, 2, 16'h0000};
    vecs[4] = '{3, 16'hFFFE, 4, 4, 16'h0001};

    // Reset state
    @(negedge clk);
    #1;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
    check("rst_dec_valid", 64'(dec_valid), 64'd0);
    check("rst_dec_inst", 64'(dec_inst), 64'd0);
    check("rst_dec_pc", 64'(dec_pc), 64'd0);
    do_reset();

    // Sequential fetch from reset, latency 1
    fetch_en = 1'b1; imem_req_ready = 1'b1; dec_ready = 1'b1; mem_lat = 1;
    pop_log.delete();
    for (k = 0; k < 20 && pop_log.size() < 3; k++) tick();
    check("seq_pops", 64'(pop_log.size() >= 3), 64'd1);
    for (int i = 0; i < 3 && i < pop_log.size(); i++)
      check("seq_pc", 64'(pop_log[i]), 64'(RESET_PC + 16'(i)));

    // Decode stall: FIFO fills to DEPTH and requests stop
    dec_ready = 1'b0;
    repeat (10) tick();
    check("stall_req_valid", 64'(imem_req_valid), 64'd0);
    check("stall_dec_valid", 64'(dec_valid), 64'd1);
    check("stall_fill", 64'(m_q.size()), 64'(DEPTH));
    check("stall_inflight", 64'(mem_q.size() + int'(imem_rsp_valid)), 64'd0);
    dec_ready = 1'b1;
    pop_log.delete();
    repeat (12) tick();
    check("resume_pops", 64'(pop_log.size() >= 8), 64'd1);

    // Table: drain in HALT, redirect, measure latency and the PC sequence
    foreach (vecs[v]) begin
      mem_lat = vecs[v].lat;
      fetch_en = 1'b0;
      for (k = 0; k < 60 && !(m_halt && mem_q.size() == 0 && !imem_rsp_valid && !dec_valid); k++)
        tick();
      check("tbl_drained", 64'(k < 60), 64'd1);
      fetch_en = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = vecs[v].pc;
      tick();
      n = 0;
      while (!dec_valid && n < 40) begin tick(); n++; end
      check("tbl_first_delay", 64'(n), 64'(vecs[v].delay));
      check("tbl_first_pc", 64'(dec_pc), 64'(vecs[v].pc));
      pop_log.delete();
      for (k = 0; k < 60 && pop_log.size() < vecs[v].n; k++) tick();
      if (pop_log.size() >= vecs[v].n)
        check("tbl_last_pc", 64'(pop_log[vecs[v].n-1]), 64'(vecs[v].last));
      else
        check("tbl_pop_count", 64'(pop_log.size()), 64'(vecs[v].n));
    end

    // Redirect with three requests in flight (latency 3)
    mem_lat = 3;
    for (k = 0; k < 30 && (mem_q.size() + int'(imem_rsp_valid)) != 3; k++) tick();
    check("inflight3_reached", 64'(k < 30), 64'd1);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    drops0 = drops;
    tick();
    imem_req_ready = 1'b1;
    for (k = 0; k < 30 && !dec_valid; k++) tick();
    check("inflight3_pc", 64'(dec_pc), 64'h0040);
    check("inflight3_drops", 64'(drops - drops0), 64'd3);

    // Redirect coinciding with a pop and a returning response
    mem_lat = 1;
    for (k = 0; k < 30 && !(dec_valid && imem_rsp_valid); k++) tick();
    check("coinc_reached", 64'(k < 30), 64'd1);
    exp_pop = (m_q.size() != 0) ? m_q[0] : 16'hDEAD;
    pops0 = pop_log.size();
    drops0 = drops;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0123;
    tick();
    check("coinc_popped", 64'(pop_log.size() - pops0), 64'd1);
    if (pop_log.size() > pops0) check("coinc_pop_pc", 64'(pop_log[pop_log.size()-1]), 64'(exp_pop));
    check("coinc_drop", 64'(drops - drops0), 64'd1);
    for (k = 0; k < 30 && !dec_valid; k++) tick();
    check("coinc_next_pc", 64'(dec_pc), 64'h0123);

    // Reset mid-stream with a full FIFO
    dec_ready = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    #1;
    check("midrst_dec_valid", 64'(dec_valid), 64'd0);
    check("midrst_req_valid", 64'(imem_req_valid), 64'd0);
    do_reset();
`ifdef IFU_PERF_CNT_EN
    check("perf_fetched_rst", 64'(perf_fetched), 64'd0);
    check("perf_flushes_rst", 64'(perf_flushes), 64'd0);
`endif
    dec_ready = 1'b1;
    for (k = 0; k < 5 && !imem_req_valid; k++) tick();
    check("midrst_addr", 64'(imem_req_addr), 64'(RESET_PC));
    pop_log.delete();
    for (k = 0; k < 20 && pop_log.size() < 1; k++) tick();
    if (pop_log.size() > 0) check("midrst_first_pc", 64'(pop_log[0]), 64'(RESET_PC));
    else check("midrst_pop_count", 64'(pop_log.size()), 64'd1);

    // Randomized traffic against the model
    pop_log.delete();
    for (int i = 0; i < 1500; i++) begin
      dec_ready      = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      fetch_en       = ($urandom_range(0, 9) != 0);
      mem_lat        = $urandom_range(1, 4);
      if ($urandom_range(0, 32) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 16'($urandom);
      end
      tick();
    end
    check("rand_progress", 64'(pop_log.size() >= 150), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
